// File: rtl/dcache_data_arbiter.sv
// Single-port dcache data SRAM arbiter: miss > store > load, miss lock for multi-beat refills,
// 1-cycle read tracking. Optional load starvation guard: DCACHE_ARB_STARVE_GUARD_EN.
module dcache_data_arbiter #(
    parameter int unsigned  DATA_WIDTH = 128,
    parameter int unsigned  NUM_WORDS  = 256,
    parameter int unsigned  MAX_WAIT   = 7,
    localparam int unsigned ADDR_WIDTH = $clog2(NUM_WORDS),
    localparam int unsigned BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  miss_req_i,
    input  logic                  miss_lock_i,
    input  logic                  miss_we_i,
    input  logic [BE_WIDTH-1:0]   miss_be_i,
    input  logic [ADDR_WIDTH-1:0] miss_addr_i,
    input  logic [DATA_WIDTH-1:0] miss_wdata_i,
    output logic                  miss_gnt_o,
    output logic                  miss_rvalid_o,
    input  logic                  st_req_i,
    input  logic [BE_WIDTH-1:0]   st_be_i,
    input  logic [ADDR_WIDTH-1:0] st_addr_i,
    input  logic [DATA_WIDTH-1:0] st_wdata_i,
    output logic                  st_gnt_o,
    input  logic                  ld_req_i,
    input  logic [ADDR_WIDTH-1:0] ld_addr_i,
    output logic                  ld_gnt_o,
    output logic                  ld_rvalid_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  sram_en_o,
    output logic                  sram_we_o,
    output logic [BE_WIDTH-1:0]   sram_be_o,
    output logic [ADDR_WIDTH-1:0] sram_addr_o,
    output logic [DATA_WIDTH-1:0] sram_wdata_o,
    input  logic [DATA_WIDTH-1:0] sram_rdata_i
);

    if ((MAX_WAIT < 1) || (MAX_WAIT > 15)) begin : g_bad_max_wait
        $error("dcache_data_arbiter: MAX_WAIT must be within 1..15");
    end
    if ((DATA_WIDTH % 8) != 0) begin : g_bad_data_width
        $error("dcache_data_arbiter: DATA_WIDTH must be a multiple of 8");
    end

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_MISS = 2'b01,
        OWN_LOAD = 2'b10
    } owner_t;

    state_t r_state;
    state_t w_state_nxt;
    owner_t r_owner;
    logic   w_miss_gnt;
    logic   w_st_gnt;
    logic   w_ld_gnt;
    logic   w_starve;

`ifdef DCACHE_ARB_STARVE_GUARD_EN
    logic [3:0] r_wait_cnt;

    assign w_starve = (r_wait_cnt >= 4'(MAX_WAIT));

    // Count IDLE cycles in which a waiting load was passed over; a load grant clears it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wait_cnt <= 4'd0;
        end else if (w_ld_gnt) begin
            r_wait_cnt <= 4'd0;
        end else if ((r_state == S_IDLE) && ld_req_i) begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
        end else begin
            r_wait_cnt <= r_wait_cnt;
        end
    end
`else
    assign w_starve = 1'b0;
`endif

    // Grant selection; reset low forces every grant off.
    always_comb begin
        w_miss_gnt = 1'b0;
        w_st_gnt   = 1'b0;
        w_ld_gnt   = 1'b0;
        if (!rst_ni) begin
            w_miss_gnt = 1'b0;
        end else if (r_state == S_LOCKED) begin
            w_miss_gnt = miss_req_i;
        end else if (w_starve && ld_req_i) begin
            w_ld_gnt = 1'b1;
        end else if (miss_req_i) begin
            w_miss_gnt = 1'b1;
        end else if (st_req_i) begin
            w_st_gnt = 1'b1;
        end else if (ld_req_i) begin
            w_ld_gnt = 1'b1;
        end else begin
            w_ld_gnt = 1'b0;
        end
    end

    // Lock tracking: a locking miss grant holds the SRAM until the miss handler releases it.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_miss_gnt && miss_lock_i) begin
                    w_state_nxt = S_LOCKED;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_LOCKED: begin
                if ((w_miss_gnt && !miss_lock_i) || (!miss_req_i && !miss_lock_i)) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_LOCKED;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Remember who issued the read so its data is steered the next cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_owner <= OWN_NONE;
        end else if (w_miss_gnt && !miss_we_i) begin
            r_owner <= OWN_MISS;
        end else if (w_ld_gnt) begin
            r_owner <= OWN_LOAD;
        end else begin
            r_owner <= OWN_NONE;
        end
    end

    // SRAM port driven from the granted payload, all zero when idle.
    always_comb begin
        sram_en_o    = 1'b0;
        sram_we_o    = 1'b0;
        sram_be_o    = {BE_WIDTH{1'b0}};
        sram_addr_o  = {ADDR_WIDTH{1'b0}};
        sram_wdata_o = {DATA_WIDTH{1'b0}};
        if (w_miss_gnt) begin
            sram_en_o    = 1'b1;
            sram_we_o    = miss_we_i;
            sram_be_o    = miss_be_i;
            sram_addr_o  = miss_addr_i;
            sram_wdata_o = miss_wdata_i;
        end else if (w_st_gnt) begin
            sram_en_o    = 1'b1;
            sram_we_o    = 1'b1;
            sram_be_o    = st_be_i;
            sram_addr_o  = st_addr_i;
            sram_wdata_o = st_wdata_i;
        end else if (w_ld_gnt) begin
            sram_en_o    = 1'b1;
            sram_addr_o  = ld_addr_i;
        end else begin
            sram_en_o    = 1'b0;
        end
    end

    // Read data is exposed only while the matching rvalid is high.
    always_comb begin
        rdata_o = {DATA_WIDTH{1'b0}};
        case (r_owner)
            OWN_MISS: rdata_o = sram_rdata_i;
            OWN_LOAD: rdata_o = sram_rdata_i;
            default:  rdata_o = {DATA_WIDTH{1'b0}};
        endcase
    end

    assign miss_gnt_o    = w_miss_gnt;
    assign st_gnt_o      = w_st_gnt;
    assign ld_gnt_o      = w_ld_gnt;
    assign miss_rvalid_o = (r_owner == OWN_MISS);
    assign ld_rvalid_o   = (r_owner == OWN_LOAD);

endmodule

// File: tb/tb_dcache_data_arbiter.sv
// Bench for dcache_data_arbiter: directed scenarios with literal expectations, then randomized
// traffic checked every cycle against a behavioural arbiter/memory model.
module tb_dcache_data_arbiter;

    localparam int DW       = 128;
    localparam int NW       = 256;
    localparam int AW       = 8;
    localparam int BW       = DW / 8;
    localparam int MAX_WAIT = 7;
`ifdef DCACHE_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          miss_req_i, miss_lock_i, miss_we_i;
    logic [BW-1:0] miss_be_i;
    logic [AW-1:0] miss_addr_i;
    logic [DW-1:0] miss_wdata_i;
    logic          miss_gnt_o, miss_rvalid_o;
    logic          st_req_i;
    logic [BW-1:0] st_be_i;
    logic [AW-1:0] st_addr_i;
    logic [DW-1:0] st_wdata_i;
    logic          st_gnt_o;
    logic          ld_req_i;
    logic [AW-1:0] ld_addr_i;
    logic          ld_gnt_o, ld_rvalid_o;
    logic [DW-1:0] rdata_o;
    logic          sram_en_o, sram_we_o;
    logic [BW-1:0] sram_be_o;
    logic [AW-1:0] sram_addr_o;
    logic [DW-1:0] sram_wdata_o;
    logic [DW-1:0] sram_rdata_i;

    dcache_data_arbiter #(.DATA_WIDTH(DW), .NUM_WORDS(NW), .MAX_WAIT(MAX_WAIT)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .miss_req_i(miss_req_i), .miss_lock_i(miss_lock_i), .miss_we_i(miss_we_i),
        .miss_be_i(miss_be_i), .miss_addr_i(miss_addr_i), .miss_wdata_i(miss_wdata_i),
        .miss_gnt_o(miss_gnt_o), .miss_rvalid_o(miss_rvalid_o),
        .st_req_i(st_req_i), .st_be_i(st_be_i), .st_addr_i(st_addr_i), .st_wdata_i(st_wdata_i),
        .st_gnt_o(st_gnt_o),
        .ld_req_i(ld_req_i), .ld_addr_i(ld_addr_i), .ld_gnt_o(ld_gnt_o), .ld_rvalid_o(ld_rvalid_o),
        .rdata_o(rdata_o),
        .sram_en_o(sram_en_o), .sram_we_o(sram_we_o), .sram_be_o(sram_be_o),
        .sram_addr_o(sram_addr_o), .sram_wdata_o(sram_wdata_o), .sram_rdata_i(sram_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // SRAM environment: 1-cycle read latency, byte-masked writes.
    logic [DW-1:0] sram_mem [NW];
    always @(posedge clk_i) begin
        if (sram_en_o) begin
            if (sram_we_o) begin
                for (int b = 0; b < BW; b++)
                    if (sram_be_o[b]) sram_mem[sram_addr_o][b*8 +: 8] <= sram_wdata_o[b*8 +: 8];
            end else begin
                sram_rdata_i <= sram_mem[sram_addr_o];
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: requester chosen this cycle (0 none, 1 miss, 2 store, 3 load).
    int            m_g;
    bit            m_locked;
    int            m_wait;
    int            m_owner;
    logic [DW-1:0] m_rdata;
    logic [DW-1:0] ref_mem [NW];

    function automatic logic [DW-1:0] init_word(int i);
        logic [DW-1:0] w;
        for (int k = 0; k < DW / 32; k++)
            w[k*32 +: 32] = 32'(i) * 32'h9E3779B1 + 32'(k) * 32'h01234567;
        return w;
    endfunction

    function automatic logic [DW-1:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_locked = 1'b0;
        m_wait   = 0;
        m_owner  = 0;
        m_rdata  = '0;
    endtask

    // Compare process: runs 1 time unit after each falling edge.
    task automatic eval_check();
        logic          e_we;
        logic [BW-1:0] e_be;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        #1;
        if (!rst_ni) model_reset();
        m_g = 0;
        if (rst_ni) begin
            if (m_locked) begin
                if (miss_req_i) m_g = 1;
            end else if (GUARD && m_wait >= MAX_WAIT && ld_req_i) m_g = 3;
            else if (miss_req_i) m_g = 1;
            else if (st_req_i)   m_g = 2;
            else if (ld_req_i)   m_g = 3;
        end
        e_we = 1'b0; e_be = '0; e_addr = '0; e_wd = '0;
        case (m_g)
            1: begin e_we = miss_we_i; e_be = miss_be_i; e_addr = miss_addr_i; e_wd = miss_wdata_i; end
            2: begin e_we = 1'b1; e_be = st_be_i; e_addr = st_addr_i; e_wd = st_wdata_i; end
            3: e_addr = ld_addr_i;
            default: ;
        endcase
        chk("miss_gnt", DW'(miss_gnt_o), DW'(m_g == 1));
        chk("st_gnt", DW'(st_gnt_o), DW'(m_g == 2));
        chk("ld_gnt", DW'(ld_gnt_o), DW'(m_g == 3));
        chk("sram_en", DW'(sram_en_o), DW'(m_g != 0));
        chk("sram_we", DW'(sram_we_o), DW'(e_we));
        chk("sram_be", DW'(sram_be_o), DW'(e_be));
        chk("sram_addr", DW'(sram_addr_o), DW'(e_addr));
        chk("sram_wdata", sram_wdata_o, e_wd);
        chk("miss_rvalid", DW'(miss_rvalid_o), DW'(m_owner == 1));
        chk("ld_rvalid", DW'(ld_rvalid_o), DW'(m_owner == 2));
        chk("rdata", rdata_o, (m_owner != 0) ? m_rdata : '0);
    endtask

    // Model state update at the rising edge.
    task automatic commit();
        if (!rst_ni) begin
            model_reset();
            return;
        end
        if (!m_locked) begin
            if (m_g == 3) m_wait = 0;
            else if (ld_req_i) m_wait++;
        end
        m_owner = 0;
        if (m_g == 1 && !miss_we_i) begin m_owner = 1; m_rdata = ref_mem[miss_addr_i]; end
        if (m_g == 3) begin m_owner = 2; m_rdata = ref_mem[ld_addr_i]; end
        for (int b = 0; b < BW; b++) begin
            if (m_g == 1 && miss_we_i && miss_be_i[b]) ref_mem[miss_addr_i][b*8 +: 8] = miss_wdata_i[b*8 +: 8];
            if (m_g == 2 && st_be_i[b]) ref_mem[st_addr_i][b*8 +: 8] = st_wdata_i[b*8 +: 8];
        end
        if (!m_locked) m_locked = (m_g == 1) && miss_lock_i;
        else if ((m_g == 1 && !miss_lock_i) || (!miss_req_i && !miss_lock_i)) m_locked = 1'b0;
    endtask

    task automatic advance();
        @(posedge clk_i);
        commit();
        @(negedge clk_i);
    endtask

    task automatic new_store();
        st_be_i    = BW'($urandom());
        st_addr_i  = AW'($urandom_range(0, 15));
        st_wdata_i = rand128();
    endtask

    // Randomized requesters: payload held until granted.
    task automatic regen(int pm, int ps, int pl);
        if (m_g == 1 || !miss_req_i) begin
            miss_req_i   = ($urandom_range(0, 99) < pm);
            miss_we_i    = 1'($urandom_range(0, 1));
            miss_lock_i  = ($urandom_range(0, 99) < 35);
            miss_be_i    = BW'($urandom());
            miss_addr_i  = AW'($urandom_range(0, 15));
            miss_wdata_i = rand128();
        end
        if (m_g == 2 || !st_req_i) begin
            st_req_i = ($urandom_range(0, 99) < ps);
            new_store();
        end
        if (m_g == 3 || !ld_req_i) begin
            ld_req_i  = ($urandom_range(0, 99) < pl);
            ld_addr_i = AW'($urandom_range(0, 15));
        end
    endtask

    logic [DW-1:0] exp_word;

    initial begin
        for (int i = 0; i < NW; i++) begin
            sram_mem[i] = init_word(i);
            ref_mem[i]  = init_word(i);
        end
        sram_mem[8'h10] = {16{8'hA5}};
        ref_mem[8'h10]  = {16{8'hA5}};
        sram_rdata_i = '0;
        model_reset();
        m_g = 0;
        rst_ni = 1'b0;
        miss_req_i = 1'b1; miss_lock_i = 1'b1; miss_we_i = 1'b1; miss_be_i = '1;
        miss_addr_i = 8'h01; miss_wdata_i = rand128();
        st_req_i = 1'b1; new_store();
        ld_req_i = 1'b1; ld_addr_i = 8'h03;
        @(negedge clk_i);

        // Reset holds everything off even with requests present.
        eval_check();
        chk("rst_miss_gnt", DW'(miss_gnt_o), DW'(1'b0));
        chk("rst_sram_en", DW'(sram_en_o), DW'(1'b0));
        advance();
        miss_req_i = 1'b0; miss_lock_i = 1'b0; st_req_i = 1'b0; ld_req_i = 1'b0;
        eval_check();
        advance();
        rst_ni = 1'b1;

        // Load-only read latency.
        ld_req_i = 1'b1; ld_addr_i = 8'h10;
        eval_check();
        chk("lat_ld_gnt", DW'(ld_gnt_o), DW'(1'b1));
        advance();
        ld_req_i = 1'b0;
        eval_check();
        chk("lat_ld_rvalid", DW'(ld_rvalid_o), DW'(1'b1));
        chk("lat_miss_rvalid", DW'(miss_rvalid_o), DW'(1'b0));
        chk("lat_rdata", rdata_o, {16{8'hA5}});
        advance();

        // All three at once: miss, then store, then load.
        miss_req_i = 1'b1; miss_we_i = 1'b1; miss_lock_i = 1'b0; miss_addr_i = 8'h01; miss_be_i = '1;
        st_req_i = 1'b1; st_addr_i = 8'h02;
        ld_req_i = 1'b1; ld_addr_i = 8'h03;
        eval_check();
        chk("prio0_miss", DW'(miss_gnt_o), DW'(1'b1));
        chk("prio0_we", DW'(sram_we_o), DW'(1'b1));
        advance();
        miss_req_i = 1'b0;
        eval_check();
        chk("prio1_st", DW'(st_gnt_o), DW'(1'b1));
        chk("prio1_we", DW'(sram_we_o), DW'(1'b1));
        advance();
        st_req_i = 1'b0;
        eval_check();
        chk("prio2_ld", DW'(ld_gnt_o), DW'(1'b1));
        chk("prio2_we", DW'(sram_we_o), DW'(1'b0));
        advance();
        ld_req_i = 1'b0;
        eval_check();
        advance();

        // Locked refill burst (with a bubble) keeps the store out.
        st_req_i = 1'b1; st_addr_i = 8'h04;
        for (int beat = 0; beat < 5; beat++) begin
            miss_req_i  = (beat != 2);
            miss_lock_i = (beat != 4);
            miss_we_i   = 1'b1;
            miss_addr_i = AW'(8'h40 + beat);
            miss_wdata_i = rand128();
            eval_check();
            chk("lock_st_gnt", DW'(st_gnt_o), DW'(1'b0));
            advance();
        end
        miss_req_i = 1'b0; miss_lock_i = 1'b0;
        eval_check();
        chk("unlock_st_gnt", DW'(st_gnt_o), DW'(1'b1));
        advance();
        st_req_i = 1'b0;

        // Partial store followed by a load of the same line.
        st_req_i = 1'b1; st_addr_i = 8'h05; st_be_i = 16'h0003;
        st_wdata_i = rand128(); st_wdata_i[15:0] = 16'hBEEF;
        eval_check();
        chk("byte_st_gnt", DW'(st_gnt_o), DW'(1'b1));
        advance();
        st_req_i = 1'b0; ld_req_i = 1'b1; ld_addr_i = 8'h05;
        eval_check();
        advance();
        ld_req_i = 1'b0;
        eval_check();
        exp_word = init_word(5);
        exp_word[15:0] = 16'hBEEF;
        chk("byte_rdata", rdata_o, exp_word);
        advance();

        // Reset while locked with a miss read in flight.
        miss_req_i = 1'b1; miss_we_i = 1'b0; miss_lock_i = 1'b1; miss_addr_i = 8'h07;
        eval_check();
        chk("rl_miss_gnt", DW'(miss_gnt_o), DW'(1'b1));
        advance();
        rst_ni = 1'b0; miss_req_i = 1'b0; st_req_i = 1'b1; st_addr_i = 8'h09;
        eval_check();
        chk("rl_miss_rvalid", DW'(miss_rvalid_o), DW'(1'b0));
        chk("rl_st_gnt_in_rst", DW'(st_gnt_o), DW'(1'b0));
        advance();
        rst_ni = 1'b1;
        eval_check();
        chk("rl_st_gnt_after", DW'(st_gnt_o), DW'(1'b1));
        advance();
        miss_lock_i = 1'b0;

        // Continuous stores against a waiting load.
        st_req_i = 1'b1; new_store();
`ifdef DCACHE_ARB_STARVE_GUARD_EN
        for (int r = 0; r < 2; r++) begin
            ld_req_i = 1'b1; ld_addr_i = 8'h20;
            for (int c = 1; c <= 8; c++) begin
                eval_check();
                chk("starve_ld_gnt", DW'(ld_gnt_o), DW'(c == 8));
                advance();
                if (m_g == 2) new_store();
            end
            ld_req_i = 1'b0;
            eval_check();
            advance();
            if (m_g == 2) new_store();
        end
`else
        ld_req_i = 1'b1; ld_addr_i = 8'h20;
        for (int c = 1; c <= 20; c++) begin
            eval_check();
            chk("starve_ld_gnt", DW'(ld_gnt_o), DW'(1'b0));
            advance();
            if (m_g == 2) new_store();
        end
        st_req_i = 1'b0;
        eval_check();
        chk("starve_ld_release", DW'(ld_gnt_o), DW'(1'b1));
        advance();
        ld_req_i = 1'b0;
`endif
        st_req_i = 1'b0;
        eval_check();
        advance();

        // Randomized traffic with varying mixes and occasional reset pulses.
        m_g = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            rst_ni = !($urandom_range(0, 299) == 0);
            eval_check();
            advance();
            case ((cyc / 500) % 4)
                0: regen(40, 50, 50);
                1: regen(5, 95, 70);
                2: regen(80, 30, 60);
                default: regen(20, 60, 90);
            endcase
        end
        rst_ni = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
